microcode_exec: RTL and testbench

Single-cycle microcode sequencer/executor for the core's control path. It runs one 32-bit micro-op per clock from a 129-entry micro-op store supplied by the parent as an unpacked array input. The store is read-only to this block. Architectural state (micro-PC, 16×32 register file, halt flag, retired-op counter) is internal; verification observes it hierarchically.

---
 rtl/microcode_exec.sv | 109 ++++++++++
 tb/tb_microcode_exec.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/microcode_exec.sv
// Single-cycle microcode sequencer/executor: one 32-bit micro-op per clock from a
// 129-word read-only store, with a 16x32 register file, halt flag and retired-op counter.
module microcode_exec (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] uops [0:128]
);

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpLdi  = 4'h1;
  localparam logic [3:0] OpLui  = 4'h2;
  localparam logic [3:0] OpAdd  = 4'h3;
  localparam logic [3:0] OpSub  = 4'h4;
  localparam logic [3:0] OpAnd  = 4'h5;
  localparam logic [3:0] OpOr   = 4'h6;
  localparam logic [3:0] OpXor  = 4'h7;
  localparam logic [3:0] OpShl  = 4'h8;
  localparam logic [3:0] OpShr  = 4'h9;
  localparam logic [3:0] OpAddi = 4'hA;
  localparam logic [3:0] OpJmp  = 4'hB;
  localparam logic [3:0] OpBeqz = 4'hC;
  localparam logic [3:0] OpBnez = 4'hD;
  localparam logic [3:0] OpRsvd = 4'hE;
  localparam logic [3:0] OpHalt = 4'hF;

  localparam logic [7:0] LastIdx = 8'd128;

  logic [7:0]  upc;
  logic [31:0] regs [0:15];
  logic        halted;
  logic [31:0] retired;

  logic        in_range;
  logic [7:0]  fetch_idx;
  logic [31:0] ir;
  logic [3:0]  op;
  logic [3:0]  rd;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [15:0] imm;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  logic        wr_en;
  logic [31:0] wr_data;
  logic [7:0]  upc_next;
  logic        do_halt;

  // Out-of-range fetch never touches the array and is decoded as HALT.
  assign in_range  = (upc <= LastIdx);
  assign fetch_idx = in_range ? upc : 8'd0;
  assign ir        = in_range ? uops[fetch_idx] : {OpHalt, 28'h0};

  assign op  = ir[31:28];
  assign rd  = ir[27:24];
  assign rs1 = ir[23:20];
  assign rs2 = ir[19:16];
  assign imm = ir[15:0];

  assign rs1_val = (rs1 == 4'd0) ? 32'd0 : regs[rs1];
  assign rs2_val = (rs2 == 4'd0) ? 32'd0 : regs[rs2];

  always_comb begin
    wr_en    = 1'b0;
    wr_data  = 32'd0;
    upc_next = upc + 8'd1;
    do_halt  = 1'b0;
    unique case (op)
      OpNop, OpRsvd: ;
      OpLdi:  begin wr_en = 1'b1; wr_data = {16'h0, imm};             end
      OpLui:  begin wr_en = 1'b1; wr_data = {imm, 16'h0};             end
      OpAdd:  begin wr_en = 1'b1; wr_data = rs1_val + rs2_val;        end
      OpSub:  begin wr_en = 1'b1; wr_data = rs1_val - rs2_val;        end
      OpAnd:  begin wr_en = 1'b1; wr_data = rs1_val & rs2_val;        end
      OpOr:   begin wr_en = 1'b1; wr_data = rs1_val | rs2_val;        end
      OpXor:  begin wr_en = 1'b1; wr_data = rs1_val ^ rs2_val;        end
      OpShl:  begin wr_en = 1'b1; wr_data = rs1_val << rs2_val[4:0];  end
      OpShr:  begin wr_en = 1'b1; wr_data = rs1_val >> rs2_val[4:0];  end
      OpAddi: begin wr_en = 1'b1; wr_data = rs1_val + {{16{imm[15]}}, imm}; end
      OpJmp:  upc_next = imm[7:0];
      OpBeqz: if (rs1_val == 32'd0) upc_next = imm[7:0];
      OpBnez: if (rs1_val != 32'd0) upc_next = imm[7:0];
      OpHalt: do_halt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upc     <= 8'd0;
      halted  <= 1'b0;
      retired <= 32'd0;
      for (int i = 0; i < 16; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (!halted) begin
      if (do_halt) begin
        halted <= 1'b1;
      end else begin
        upc     <= upc_next;
        retired <= retired + 32'd1;
        if (wr_en && (rd != 4'd0)) begin
          regs[rd] <= wr_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_microcode_exec.sv
// Directed self-checking bench for microcode_exec; state is observed hierarchically.
module tb_microcode_exec;

  logic        clk;
  logic        reset;
  logic [31:0] uops [0:128];

  int n_checks = 0;
  int n_fail   = 0;

  microcode_exec dut (
    .clk   (clk),
    .reset (reset),
    .uops  (uops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2,
                                      input logic [15:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  task automatic clear_uops();
    for (int i = 0; i <= 128; i++) uops[i] = 32'd0;
  endtask

  task automatic load_prog1();
    clear_uops();
    uops[0] = enc(4'h1, 4'd1, 4'd0, 4'd0, 16'd5);
    uops[1] = enc(4'h1, 4'd2, 4'd0, 4'd0, 16'd3);
    uops[2] = enc(4'h3, 4'd3, 4'd1, 4'd2, 16'd0);
    uops[3] = enc(4'h4, 4'd4, 4'd2, 4'd1, 16'd0);
    uops[4] = enc(4'h2, 4'd5, 4'd0, 4'd0, 16'h1234);
    uops[5] = enc(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
  endtask

  // Reset is held low around the store change; released on a falling edge.
  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_until_halt(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && !dut.halted; i++) begin
      @(posedge clk);
      #1;
    end
    check(tag, {31'd0, dut.halted}, 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    clear_uops();

    // Straight-line ALU program
    load_prog1();
    #12;
    release_reset();
    run_until_halt("p1_halted", 50);
    check("p1_r1", dut.regs[1], 32'd5);
    check("p1_r3", dut.regs[3], 32'd8);
    check("p1_r4", dut.regs[4], 32'hFFFF_FFFE);
    check("p1_r5", dut.regs[5], 32'h1234_0000);
    check("p1_upc", {24'd0, dut.upc}, 32'd5);
    check("p1_retired", dut.retired, 32'd5);

    // Halt freeze over 10 cycles
    repeat (10) @(posedge clk);
    #1;
    check("frz_upc", {24'd0, dut.upc}, 32'd5);
    check("frz_retired", dut.retired, 32'd5);
    check("frz_r3", dut.regs[3], 32'd8);
    check("frz_halted", {31'd0, dut.halted}, 32'd1);

    // Reset pulse restarts at uops[0]
    @(negedge clk);
    reset = 1'b0;
    #2;
    release_reset();
    @(posedge clk);
    #1;
    check("rst_upc", {24'd0, dut.upc}, 32'd1);
    check("rst_r1", dut.regs[1], 32'd5);
    check("rst_r3", dut.regs[3], 32'd0);
    check("rst_retired", dut.retired, 32'd1);
    check("rst_halted", {31'd0, dut.halted}, 32'd0);

    // r0, shifts, logic ops, reserved opcode, taken BEQZ
    @(negedge clk);
    reset = 1'b0;
    clear_uops();
    uops[0]  = enc(4'h1, 4'd0, 4'd0, 4'd0, 16'd7);
    uops[1]  = enc(4'h1, 4'd1, 4'd0, 4'd0, 16'd1);
    uops[2]  = enc(4'h1, 4'd2, 4'd0, 4'd0, 16'd31);
    uops[3]  = enc(4'h8, 4'd3, 4'd1, 4'd2, 16'd0);
    uops[4]  = enc(4'h9, 4'd4, 4'd3, 4'd2, 16'd0);
    uops[5]  = enc(4'hA, 4'd5, 4'd0, 4'd0, 16'hFFFF);
    uops[6]  = enc(4'hE, 4'd10, 4'd1, 4'd2, 16'h0055);
    uops[7]  = enc(4'h6, 4'd6, 4'd3, 4'd4, 16'd0);
    uops[8]  = enc(4'h7, 4'd7, 4'd6, 4'd5, 16'd0);
    uops[9]  = enc(4'h5, 4'd8, 4'd5, 4'd2, 16'd0);
    uops[10] = enc(4'hC, 4'd0, 4'd0, 4'd0, 16'd12);
    uops[11] = enc(4'h1, 4'd9, 4'd0, 4'd0, 16'h0BAD);
    uops[12] = enc(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
    release_reset();
    repeat (4) @(posedge clk);
    #1;
    check("mid_upc_pre", {24'd0, dut.upc}, 32'd4);
    reset = 1'b0;
    #1;
    check("mid_upc", {24'd0, dut.upc}, 32'd0);
    check("mid_halted", {31'd0, dut.halted}, 32'd0);
    check("mid_retired", dut.retired, 32'd0);
    for (int i = 0; i < 16; i++) check($sformatf("mid_r%0d", i), dut.regs[i], 32'd0);
    release_reset();
    run_until_halt("p2_halted", 50);
    check("p2_r0", dut.regs[0], 32'd0);
    check("p2_r3", dut.regs[3], 32'h8000_0000);
    check("p2_r4", dut.regs[4], 32'd1);
    check("p2_r5", dut.regs[5], 32'hFFFF_FFFF);
    check("p2_r6", dut.regs[6], 32'h8000_0001);
    check("p2_r7", dut.regs[7], 32'h7FFF_FFFE);
    check("p2_r8", dut.regs[8], 32'd31);
    check("p2_r9", dut.regs[9], 32'd0);
    check("p2_r10", dut.regs[10], 32'd0);
    check("p2_upc", {24'd0, dut.upc}, 32'd12);
    check("p2_retired", dut.retired, 32'd11);

    // Countdown loop
    @(negedge clk);
    reset = 1'b0;
    clear_uops();
    uops[0] = enc(4'h1, 4'd1, 4'd0, 4'd0, 16'd4);
    uops[1] = enc(4'hA, 4'd1, 4'd1, 4'd0, 16'hFFFF);
    uops[2] = enc(4'hD, 4'd0, 4'd1, 4'd0, 16'd1);
    uops[3] = enc(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
    release_reset();
    run_until_halt("loop_halted", 50);
    check("loop_r1", dut.regs[1], 32'd0);
    check("loop_upc", {24'd0, dut.upc}, 32'd3);
    check("loop_retired", dut.retired, 32'd9);

    // Out-of-range fetch after executing word 128
    @(negedge clk);
    reset = 1'b0;
    clear_uops();
    uops[0]   = enc(4'hB, 4'd0, 4'd0, 4'd0, 16'd128);
    uops[128] = enc(4'h0, 4'd0, 4'd0, 4'd0, 16'd0);
    release_reset();
    @(posedge clk);
    #1;
    check("oor_upc_jmp", {24'd0, dut.upc}, 32'd128);
    @(posedge clk);
    #1;
    check("oor_upc_129", {24'd0, dut.upc}, 32'd129);
    check("oor_not_halted", {31'd0, dut.halted}, 32'd0);
    @(posedge clk);
    #1;
    check("oor_halted", {31'd0, dut.halted}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("oor_upc_hold", {24'd0, dut.upc}, 32'd129);
    check("oor_retired", dut.retired, 32'd2);
    check("oor_r1", dut.regs[1], 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
